// File: rtl/ysyx_24110006_axi_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ysyx_24110006_axi_pkg -- AXI4 response/burst codes, FSM state types, helpers. Rev 1.0
// ---------------------------------------------------------------------------
package ysyx_24110006_axi_pkg;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;
  localparam logic [1:0] RESP_DECERR = 2'b11;

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;

  typedef enum logic [1:0] {
    R_IDLE = 2'd0,
    R_WAIT = 2'd1,
    R_DATA = 2'd2
  } rd_state_t;

  typedef enum logic [1:0] {
    W_IDLE = 2'd0,
    W_DATA = 2'd1,
    W_RESP = 2'd2
  } wr_state_t;

  // Response codes are ordered so that the numerically larger one is the worse one.
  function automatic logic [1:0] resp_worst(input logic [1:0] a, input logic [1:0] b);
    return (a > b) ? a : b;
  endfunction

  function automatic logic burst_bad(input logic [1:0] burst, input logic [2:0] size);
    return !((burst == BURST_FIXED) || (burst == BURST_INCR)) || (size > 3'd2);
  endfunction

  function automatic logic [31:0] next_addr(input logic [31:0] addr, input logic [1:0] burst,
                                            input logic [2:0] size);
    return (burst == BURST_INCR) ? addr + (32'd1 << size) : addr;
  endfunction

  function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                              input logic [31:0] new_word,
                                              input logic [3:0]  strb);
    logic [31:0] r;
    r = old_word;
    for (int b = 0; b < 4; b++) begin
      if (strb[b]) r[8*b +: 8] = new_word[8*b +: 8];
    end
    return r;
  endfunction

endpackage
`default_nettype wire

// File: rtl/ysyx_24110006_sram_slave_lfsr4.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ysyx_24110006_lfsr4 -- free-running 4-bit LFSR, x^4+x^3+1, seed 4'b1001. Rev 1.0
// ---------------------------------------------------------------------------
module ysyx_24110006_lfsr4 (
  input  logic       clk,
  input  logic       rst,
  output logic [3:0] q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) q <= 4'b1001;
    else     q <= {q[2:0], q[3] ^ q[2]};
  end

endmodule
`default_nettype wire

// File: rtl/ysyx_24110006_sram_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// ysyx_24110006_sram_slave -- AXI4 responder over a DEPTH_WORDS x 32 array. Rev 1.0
// Define YSYX_24110006_SRAM_RAND_DELAY_EN to draw read-wait and B delays from an LFSR.
// ---------------------------------------------------------------------------
module ysyx_24110006_sram_slave
  import ysyx_24110006_axi_pkg::*;
#(
  parameter logic [31:0] ADDR_BASE   = 32'h8000_0000,
  parameter int          DEPTH_WORDS = 1024,
  parameter int          READ_LAT    = 1
) (
  input  logic        i_clock,
  input  logic        i_reset,
  input  logic [31:0] i_axi_araddr,
  input  logic        i_axi_arvalid,
  output logic        o_axi_arready,
  input  logic [3:0]  i_axi_arid,
  input  logic [7:0]  i_axi_arlen,
  input  logic [2:0]  i_axi_arsize,
  input  logic [1:0]  i_axi_arburst,
  output logic [31:0] o_axi_rdata,
  output logic        o_axi_rvalid,
  output logic [1:0]  o_axi_rresp,
  input  logic        i_axi_rready,
  output logic [3:0]  o_axi_rid,
  output logic        o_axi_rlast,
  input  logic [31:0] i_axi_awaddr,
  input  logic        i_axi_awvalid,
  output logic        o_axi_awready,
  input  logic [3:0]  i_axi_awid,
  input  logic [7:0]  i_axi_awlen,
  input  logic [2:0]  i_axi_awsize,
  input  logic [1:0]  i_axi_awburst,
  input  logic [31:0] i_axi_wdata,
  input  logic [3:0]  i_axi_wstrb,
  input  logic        i_axi_wvalid,
  output logic        o_axi_wready,
  input  logic        i_axi_wlast,
  output logic [1:0]  o_axi_bresp,
  output logic        o_axi_bvalid,
  input  logic        i_axi_bready,
  output logic [3:0]  o_axi_bid
);

  localparam int          IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [32:0] SPAN  = 33'(DEPTH_WORDS) << 2;

  function automatic logic in_range(input logic [31:0] a);
    return (a >= ADDR_BASE) && ({1'b0, a - ADDR_BASE} < SPAN);
  endfunction

  function automatic logic [IDX_W-1:0] word_idx(input logic [31:0] a);
    return IDX_W'((a - ADDR_BASE) >> 2);
  endfunction

  logic [31:0] mem [DEPTH_WORDS];

  logic [2:0] rd_lat;
  logic [1:0] b_dly;
`ifdef YSYX_24110006_SRAM_RAND_DELAY_EN
  logic [3:0] lfsr_q;
  ysyx_24110006_lfsr4 u_lfsr (
    .clk (i_clock),
    .rst (i_reset),
    .q   (lfsr_q)
  );
  assign rd_lat = lfsr_q[2:0];
  assign b_dly  = lfsr_q[1:0];
`else
  assign rd_lat = 3'(READ_LAT);
  assign b_dly  = 2'd0;
`endif

  // Read channel state
  rd_state_t   rd_state;
  logic [31:0] rd_addr;
  logic [7:0]  rd_len;
  logic [7:0]  rd_beat;
  logic [2:0]  rd_size;
  logic [2:0]  rd_wait;
  logic [1:0]  rd_burst;
  logic        rd_bad;

  // Write channel state
  wr_state_t   wr_state;
  logic [31:0] wr_addr;
  logic [7:0]  wr_len;
  logic [7:0]  wr_beat;
  logic [2:0]  wr_size;
  logic [1:0]  wr_burst;
  logic        wr_bad;
  logic [1:0]  wr_resp;
  logic [1:0]  b_wait;

  logic ar_fire, r_fire, aw_fire, w_fire;
  assign ar_fire = o_axi_arready & i_axi_arvalid;
  assign r_fire  = o_axi_rvalid  & i_axi_rready;
  assign aw_fire = o_axi_awready & i_axi_awvalid;
  assign w_fire  = o_axi_wready  & i_axi_wvalid;

  logic             wr_hit;
  logic             wr_en;
  logic [IDX_W-1:0] wr_idx;
  logic [1:0]       wr_beat_resp;
  logic [1:0]       wr_resp_next;

  assign wr_hit = in_range(wr_addr);
  assign wr_en  = w_fire & ~wr_bad & wr_hit;
  assign wr_idx = word_idx(wr_addr);

  // A wlast that disagrees with awlen terminates the burst with SLVERR.
  always_comb begin
    wr_beat_resp = RESP_OKAY;
    if (wr_bad)       wr_beat_resp = RESP_SLVERR;
    else if (!wr_hit) wr_beat_resp = RESP_DECERR;
    wr_resp_next = resp_worst(wr_resp, wr_beat_resp);
    if (i_axi_wlast != (wr_beat == wr_len))
      wr_resp_next = resp_worst(wr_resp_next, RESP_SLVERR);
  end

  always_ff @(posedge i_clock) begin
    if (wr_en) begin
      for (int b = 0; b < 4; b++) begin
        if (i_axi_wstrb[b]) mem[wr_idx][8*b +: 8] <= i_axi_wdata[8*b +: 8];
      end
    end
  end

  // Address of the beat about to be presented, with same-edge write forwarding so a
  // committing write is already visible to the beat registered on that edge.
  logic [31:0]      fetch_addr;
  logic             fetch_bad;
  logic [IDX_W-1:0] fetch_idx;
  logic [31:0]      fetch_word;
  logic [31:0]      fetch_data;
  logic [1:0]       fetch_resp;

  always_comb begin
    case (rd_state)
      R_IDLE: begin
        fetch_addr = i_axi_araddr;
        fetch_bad  = burst_bad(i_axi_arburst, i_axi_arsize);
      end
      R_WAIT: begin
        fetch_addr = rd_addr;
        fetch_bad  = rd_bad;
      end
      default: begin
        fetch_addr = next_addr(rd_addr, rd_burst, rd_size);
        fetch_bad  = rd_bad;
      end
    endcase
    fetch_idx  = word_idx(fetch_addr);
    fetch_word = mem[fetch_idx];
    if (wr_en && (wr_idx == fetch_idx))
      fetch_word = merge_bytes(fetch_word, i_axi_wdata, i_axi_wstrb);
    fetch_data = fetch_word;
    fetch_resp = RESP_OKAY;
    if (fetch_bad) begin
      fetch_data = 32'd0;
      fetch_resp = RESP_SLVERR;
    end else if (!in_range(fetch_addr)) begin
      fetch_data = 32'd0;
      fetch_resp = RESP_DECERR;
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      rd_state      <= R_IDLE;
      o_axi_arready <= 1'b0;
      o_axi_rvalid  <= 1'b0;
      o_axi_rdata   <= 32'd0;
      o_axi_rresp   <= RESP_OKAY;
      o_axi_rid     <= 4'd0;
      o_axi_rlast   <= 1'b0;
      rd_addr       <= 32'd0;
      rd_len        <= 8'd0;
      rd_beat       <= 8'd0;
      rd_size       <= 3'd0;
      rd_wait       <= 3'd0;
      rd_burst      <= BURST_FIXED;
      rd_bad        <= 1'b0;
    end else begin
      case (rd_state)
        R_IDLE: begin
          o_axi_arready <= 1'b1;
          if (ar_fire) begin
            o_axi_arready <= 1'b0;
            rd_addr       <= i_axi_araddr;
            rd_len        <= i_axi_arlen;
            rd_size       <= i_axi_arsize;
            rd_burst      <= i_axi_arburst;
            rd_bad        <= burst_bad(i_axi_arburst, i_axi_arsize);
            rd_beat       <= 8'd0;
            o_axi_rid     <= i_axi_arid;
            if (rd_lat == 3'd0) begin
              rd_state     <= R_DATA;
              o_axi_rvalid <= 1'b1;
              o_axi_rdata  <= fetch_data;
              o_axi_rresp  <= fetch_resp;
              o_axi_rlast  <= (i_axi_arlen == 8'd0);
            end else begin
              rd_state <= R_WAIT;
              rd_wait  <= rd_lat - 3'd1;
            end
          end
        end
        R_WAIT: begin
          if (rd_wait == 3'd0) begin
            rd_state     <= R_DATA;
            o_axi_rvalid <= 1'b1;
            o_axi_rdata  <= fetch_data;
            o_axi_rresp  <= fetch_resp;
            o_axi_rlast  <= (rd_len == 8'd0);
          end else begin
            rd_wait <= rd_wait - 3'd1;
          end
        end
        R_DATA: begin
          if (r_fire) begin
            if (o_axi_rlast) begin
              rd_state      <= R_IDLE;
              o_axi_rvalid  <= 1'b0;
              o_axi_rlast   <= 1'b0;
              o_axi_arready <= 1'b1;
            end else begin
              rd_beat     <= rd_beat + 8'd1;
              rd_addr     <= fetch_addr;
              o_axi_rdata <= fetch_data;
              o_axi_rresp <= fetch_resp;
              o_axi_rlast <= ((rd_beat + 8'd1) == rd_len);
            end
          end
        end
        default: rd_state <= R_IDLE;
      endcase
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      wr_state      <= W_IDLE;
      o_axi_awready <= 1'b0;
      o_axi_wready  <= 1'b0;
      o_axi_bvalid  <= 1'b0;
      o_axi_bresp   <= RESP_OKAY;
      o_axi_bid     <= 4'd0;
      wr_addr       <= 32'd0;
      wr_len        <= 8'd0;
      wr_beat       <= 8'd0;
      wr_size       <= 3'd0;
      wr_burst      <= BURST_FIXED;
      wr_bad        <= 1'b0;
      wr_resp       <= RESP_OKAY;
      b_wait        <= 2'd0;
    end else begin
      case (wr_state)
        W_IDLE: begin
          o_axi_awready <= 1'b1;
          if (aw_fire) begin
            o_axi_awready <= 1'b0;
            o_axi_wready  <= 1'b1;
            wr_state      <= W_DATA;
            wr_addr       <= i_axi_awaddr;
            wr_len        <= i_axi_awlen;
            wr_size       <= i_axi_awsize;
            wr_burst      <= i_axi_awburst;
            wr_bad        <= burst_bad(i_axi_awburst, i_axi_awsize);
            wr_beat       <= 8'd0;
            wr_resp       <= RESP_OKAY;
            o_axi_bid     <= i_axi_awid;
          end
        end
        W_DATA: begin
          if (w_fire) begin
            wr_beat <= wr_beat + 8'd1;
            wr_addr <= next_addr(wr_addr, wr_burst, wr_size);
            wr_resp <= wr_resp_next;
            if (i_axi_wlast) begin
              o_axi_wready <= 1'b0;
              wr_state     <= W_RESP;
              if (b_dly == 2'd0) begin
                o_axi_bvalid <= 1'b1;
                o_axi_bresp  <= wr_resp_next;
              end else begin
                b_wait <= b_dly - 2'd1;
              end
            end
          end
        end
        W_RESP: begin
          if (!o_axi_bvalid) begin
            if (b_wait == 2'd0) begin
              o_axi_bvalid <= 1'b1;
              o_axi_bresp  <= wr_resp;
            end else begin
              b_wait <= b_wait - 2'd1;
            end
          end else if (i_axi_bready) begin
            o_axi_bvalid  <= 1'b0;
            o_axi_awready <= 1'b1;
            wr_state      <= W_IDLE;
          end
        end
        default: wr_state <= W_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ysyx_24110006_sram_slave.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_ysyx_24110006_sram_slave -- directed scoreboard bench for the AXI4 SRAM responder. Rev 1.0
// ---------------------------------------------------------------------------
module tb_ysyx_24110006_sram_slave;

  localparam logic [31:0] BASE     = 32'h8000_0000;
  localparam int          READ_LAT = 1;
  localparam int          TMO      = 300;

  logic        i_clock, i_reset;
  logic [31:0] i_axi_araddr;
  logic        i_axi_arvalid, o_axi_arready;
  logic [3:0]  i_axi_arid;
  logic [7:0]  i_axi_arlen;
  logic [2:0]  i_axi_arsize;
  logic [1:0]  i_axi_arburst;
  logic [31:0] o_axi_rdata;
  logic        o_axi_rvalid;
  logic [1:0]  o_axi_rresp;
  logic        i_axi_rready;
  logic [3:0]  o_axi_rid;
  logic        o_axi_rlast;
  logic [31:0] i_axi_awaddr;
  logic        i_axi_awvalid, o_axi_awready;
  logic [3:0]  i_axi_awid;
  logic [7:0]  i_axi_awlen;
  logic [2:0]  i_axi_awsize;
  logic [1:0]  i_axi_awburst;
  logic [31:0] i_axi_wdata;
  logic [3:0]  i_axi_wstrb;
  logic        i_axi_wvalid, o_axi_wready, i_axi_wlast;
  logic [1:0]  o_axi_bresp;
  logic        o_axi_bvalid, i_axi_bready;
  logic [3:0]  o_axi_bid;

  ysyx_24110006_sram_slave #(
    .ADDR_BASE   (BASE),
    .DEPTH_WORDS (1024),
    .READ_LAT    (READ_LAT)
  ) dut (
    .i_clock       (i_clock),
    .i_reset       (i_reset),
    .i_axi_araddr  (i_axi_araddr),
    .i_axi_arvalid (i_axi_arvalid),
    .o_axi_arready (o_axi_arready),
    .i_axi_arid    (i_axi_arid),
    .i_axi_arlen   (i_axi_arlen),
    .i_axi_arsize  (i_axi_arsize),
    .i_axi_arburst (i_axi_arburst),
    .o_axi_rdata   (o_axi_rdata),
    .o_axi_rvalid  (o_axi_rvalid),
    .o_axi_rresp   (o_axi_rresp),
    .i_axi_rready  (i_axi_rready),
    .o_axi_rid     (o_axi_rid),
    .o_axi_rlast   (o_axi_rlast),
    .i_axi_awaddr  (i_axi_awaddr),
    .i_axi_awvalid (i_axi_awvalid),
    .o_axi_awready (o_axi_awready),
    .i_axi_awid    (i_axi_awid),
    .i_axi_awlen   (i_axi_awlen),
    .i_axi_awsize  (i_axi_awsize),
    .i_axi_awburst (i_axi_awburst),
    .i_axi_wdata   (i_axi_wdata),
    .i_axi_wstrb   (i_axi_wstrb),
    .i_axi_wvalid  (i_axi_wvalid),
    .o_axi_wready  (o_axi_wready),
    .i_axi_wlast   (i_axi_wlast),
    .o_axi_bresp   (o_axi_bresp),
    .o_axi_bvalid  (o_axi_bvalid),
    .i_axi_bready  (i_axi_bready),
    .o_axi_bid     (o_axi_bid)
  );

  initial i_clock = 1'b0;
  always #5 i_clock = ~i_clock;

  typedef struct packed {
    logic [31:0] data;
    logic [1:0]  resp;
    logic        last;
  } rbeat_t;

  rbeat_t      rq[$];
  logic [1:0]  bq[$];
  logic [31:0] model [int];
  int checks   = 0;
  int failures = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic tb_in_range(input logic [31:0] a);
    return (a >= BASE) && (a < BASE + 32'h1000);
  endfunction

  function automatic int tb_idx(input logic [31:0] a);
    return int'((a - BASE) >> 2);
  endfunction

  task automatic do_write(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                          input logic [1:0] burst, input logic [3:0] id, input logic [31:0] d0,
                          input logic [3:0] strb, input int nbeats, input logic [1:0] exp_resp);
    logic [31:0] a, w;
    logic [1:0]  er;
    int n;
    bq.push_back(exp_resp);
    a = addr;
    for (int i = 0; i < nbeats; i++) begin
      if ((burst == 2'b00 || burst == 2'b01) && size <= 3'd2 && tb_in_range(a)) begin
        w = model.exists(tb_idx(a)) ? model[tb_idx(a)] : 32'd0;
        for (int b = 0; b < 4; b++) if (strb[b]) w[8*b +: 8] = (d0 + i) >> (8*b);
        model[tb_idx(a)] = w;
      end
      if (burst == 2'b01) a = a + (32'd1 << size);
    end
    i_axi_awaddr = addr; i_axi_awlen = len; i_axi_awsize = size;
    i_axi_awburst = burst; i_axi_awid = id; i_axi_awvalid = 1'b1;
    n = 0;
    while (!o_axi_awready && n < TMO) begin @(posedge i_clock); #1; n++; end
    chk("awready", o_axi_awready, 1);
    @(posedge i_clock); #1;
    i_axi_awvalid = 1'b0;
    for (int i = 0; i < nbeats; i++) begin
      i_axi_wdata = d0 + i; i_axi_wstrb = strb;
      i_axi_wlast = (i == nbeats - 1); i_axi_wvalid = 1'b1;
      n = 0;
      while (!o_axi_wready && n < TMO) begin @(posedge i_clock); #1; n++; end
      chk("wready", o_axi_wready, 1);
      @(posedge i_clock); #1;
      i_axi_wvalid = 1'b0; i_axi_wlast = 1'b0;
    end
    i_axi_bready = 1'b1;
    n = 0;
    while (!o_axi_bvalid && n < TMO) begin @(posedge i_clock); #1; n++; end
    chk("bvalid", o_axi_bvalid, 1);
    er = bq.pop_front();
    chk("bresp", o_axi_bresp, er);
    chk("bid", o_axi_bid, id);
    @(posedge i_clock); #1;
    i_axi_bready = 1'b0;
    chk("bvalid_clear", o_axi_bvalid, 0);
  endtask

  task automatic do_read(input logic [31:0] addr, input logic [7:0] len, input logic [2:0] size,
                         input logic [1:0] burst, input logic [3:0] id,
                         input int stall_at, input int stall_n);
    logic [31:0] a;
    logic        bad;
    rbeat_t      e;
    int n;
    a   = addr;
    bad = !(burst == 2'b00 || burst == 2'b01) || size > 3'd2;
    for (int i = 0; i <= int'(len); i++) begin
      if (bad)                    e = '{data: 32'd0, resp: 2'b10, last: (i == int'(len))};
      else if (!tb_in_range(a))   e = '{data: 32'd0, resp: 2'b11, last: (i == int'(len))};
      else                        e = '{data: model[tb_idx(a)], resp: 2'b00, last: (i == int'(len))};
      rq.push_back(e);
      if (burst == 2'b01) a = a + (32'd1 << size);
    end
    i_axi_araddr = addr; i_axi_arlen = len; i_axi_arsize = size;
    i_axi_arburst = burst; i_axi_arid = id; i_axi_arvalid = 1'b1;
    n = 0;
    while (!o_axi_arready && n < TMO) begin @(posedge i_clock); #1; n++; end
    chk("arready", o_axi_arready, 1);
    @(posedge i_clock); #1;
    i_axi_arvalid = 1'b0;
    n = 1;
    while (!o_axi_rvalid && n < TMO) begin @(posedge i_clock); #1; n++; end
`ifndef YSYX_24110006_SRAM_RAND_DELAY_EN
    chk("read_latency", n, READ_LAT + 1);
`endif
    for (int i = 0; i <= int'(len); i++) begin
      n = 0;
      while (!o_axi_rvalid && n < TMO) begin @(posedge i_clock); #1; n++; end
      chk("rvalid", o_axi_rvalid, 1);
      e = rq.pop_front();
      if (i == stall_at) begin
        repeat (stall_n) begin
          @(posedge i_clock); #1;
          chk("stall_rdata", o_axi_rdata, e.data);
          chk("stall_rlast", o_axi_rlast, e.last);
        end
      end
      chk("rdata", o_axi_rdata, e.data);
      chk("rresp", o_axi_rresp, e.resp);
      chk("rlast", o_axi_rlast, e.last);
      chk("rid", o_axi_rid, id);
      i_axi_rready = 1'b1;
      @(posedge i_clock); #1;
      i_axi_rready = 1'b0;
    end
    chk("rvalid_end", o_axi_rvalid, 0);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "bench watchdog expired");
  end

  initial begin
    int n;
    i_reset = 1'b1;
    i_axi_araddr = '0; i_axi_arvalid = 1'b0; i_axi_arid = '0; i_axi_arlen = '0;
    i_axi_arsize = '0; i_axi_arburst = '0; i_axi_rready = 1'b0;
    i_axi_awaddr = '0; i_axi_awvalid = 1'b0; i_axi_awid = '0; i_axi_awlen = '0;
    i_axi_awsize = '0; i_axi_awburst = '0; i_axi_wdata = '0; i_axi_wstrb = '0;
    i_axi_wvalid = 1'b0; i_axi_wlast = 1'b0; i_axi_bready = 1'b0;

    // Reset state: every output low, handshakes open one cycle after release
    repeat (3) @(posedge i_clock);
    #1;
    chk("rst_arready", o_axi_arready, 0);
    chk("rst_awready", o_axi_awready, 0);
    chk("rst_wready", o_axi_wready, 0);
    chk("rst_rvalid", o_axi_rvalid, 0);
    chk("rst_bvalid", o_axi_bvalid, 0);
    chk("rst_rdata", o_axi_rdata, 0);
    i_reset = 1'b0;
    chk("rel_arready_pre", o_axi_arready, 0);
    @(posedge i_clock); #1;
    chk("rel_arready", o_axi_arready, 1);
    chk("rel_awready", o_axi_awready, 1);

    // 256-beat INCR write then read back (8-bit beat counter)
    do_write(BASE, 8'd255, 3'd2, 2'b01, 4'h1, 32'h1000_0000, 4'hF, 256, 2'b00);
    do_read (BASE, 8'd255, 3'd2, 2'b01, 4'h2, -1, 0);

    // Four-beat INCR write/read of 1..4
    do_write(BASE + 32'h10, 8'd3, 3'd2, 2'b01, 4'h3, 32'd1, 4'hF, 4, 2'b00);
    do_read (BASE + 32'h10, 8'd3, 3'd2, 2'b01, 4'h4, -1, 0);

    // Partial strobe merge
    do_write(BASE + 32'h4, 8'd0, 3'd2, 2'b01, 4'h5, 32'h1122_3344, 4'hF, 1, 2'b00);
    do_write(BASE + 32'h4, 8'd0, 3'd2, 2'b01, 4'h6, 32'hAABB_CCDD, 4'b0101, 1, 2'b00);
    do_read (BASE + 32'h4, 8'd0, 3'd2, 2'b01, 4'h7, -1, 0);

    // Crossing the top of the array: last word OKAY, next DECERR
    do_write(BASE + 32'hFFC, 8'd0, 3'd2, 2'b01, 4'h8, 32'hCAFE_0001, 4'hF, 1, 2'b00);
    do_read (BASE + 32'hFFC, 8'd1, 3'd2, 2'b01, 4'h9, -1, 0);
    do_write(BASE + 32'hFFC, 8'd1, 3'd2, 2'b01, 4'hA, 32'h5555_0000, 4'hF, 2, 2'b11);
    do_read (BASE + 32'hFFC, 8'd0, 3'd2, 2'b01, 4'hB, -1, 0);

    // WRAP read and oversize write are rejected whole
    do_read (BASE + 32'h10, 8'd1, 3'd2, 2'b10, 4'hC, -1, 0);
    do_write(BASE + 32'h20, 8'd0, 3'd3, 2'b01, 4'hD, 32'h9999_9999, 4'hF, 1, 2'b10);
    do_read (BASE + 32'h20, 8'd0, 3'd2, 2'b01, 4'hE, -1, 0);

    // FIXED burst repeats the same word
    do_read (BASE + 32'h14, 8'd2, 3'd2, 2'b00, 4'hF, -1, 0);

    // rready stalled 5 cycles while an unrelated write completes
    fork
      do_read (BASE, 8'd3, 3'd2, 2'b01, 4'h1, 1, 5);
      begin
        repeat (3) @(posedge i_clock);
        #1;
        do_write(BASE + 32'h100, 8'd0, 3'd2, 2'b01, 4'h2, 32'hDEAD_BEEF, 4'hF, 1, 2'b00);
      end
    join
    do_read (BASE + 32'h100, 8'd0, 3'd2, 2'b01, 4'h3, -1, 0);

    // Early wlast: SLVERR, but both beats land
    do_write(BASE + 32'h40, 8'd2, 3'd2, 2'b01, 4'h4, 32'h7777_0000, 4'hF, 2, 2'b10);
    do_read (BASE + 32'h40, 8'd2, 3'd2, 2'b01, 4'h5, -1, 0);

    // Reset pulsed while a read is presenting data
    i_axi_araddr = BASE + 32'h10; i_axi_arlen = 8'd3; i_axi_arsize = 3'd2;
    i_axi_arburst = 2'b01; i_axi_arid = 4'h6; i_axi_arvalid = 1'b1;
    n = 0;
    while (!o_axi_arready && n < TMO) begin @(posedge i_clock); #1; n++; end
    chk("rst_ar_arready", o_axi_arready, 1);
    @(posedge i_clock); #1;
    i_axi_arvalid = 1'b0;
    n = 0;
    while (!o_axi_rvalid && n < TMO) begin @(posedge i_clock); #1; n++; end
    chk("rst_ar_rvalid", o_axi_rvalid, 1);
    #2;
    i_reset = 1'b1;
    #1;
    chk("rst_mid_rvalid", o_axi_rvalid, 0);
    chk("rst_mid_rlast", o_axi_rlast, 0);
    chk("rst_mid_arready", o_axi_arready, 0);
    @(posedge i_clock); #1;
    i_reset = 1'b0;
    chk("rst_rel_arready_pre", o_axi_arready, 0);
    @(posedge i_clock); #1;
    chk("rst_rel_arready", o_axi_arready, 1);
    chk("rst_rel_rvalid", o_axi_rvalid, 0);

    // Array contents survive reset
    do_read (BASE + 32'h10, 8'd3, 3'd2, 2'b01, 4'h7, -1, 0);

    chk("rq_empty", rq.size(), 0);
    chk("bq_empty", bq.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
